// File: rtl/pairmatch_pkg.sv
// Shared types and helpers for the pairwise-equality sequencer.
package pairmatch_pkg;

    // Two-phase sequencer: gather samples, then hold the result for the consumer.
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int DEFAULT_N = 5;

    // Position of the (i,j) comparison in the flattened matrix; row 0 sits at the MSBs.
    function automatic int match_bit(input int n, input int i, input int j);
        return n * n - 1 - (i * n + j);
    endfunction

endpackage

// File: rtl/pairmatch_matrix.sv
// Combinational N x N pairwise-equality matrix over an N-bit sample vector.
module pairmatch_matrix
    import pairmatch_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0]   samples,
    output logic [N*N-1:0] matrix
);

    // Bit (i,j) is set when samples i and j agree; the diagonal is therefore always 1.
    always_comb begin
        // NOTE: default every output first so no path through the block can infer a latch.
        matrix = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                matrix[match_bit(N, i, j)] = ~(samples[i] ^ samples[j]);
            end
        end
    end

endmodule

// File: rtl/pairmatch_seq.sv
// Serial front-end for the pairwise-equality datapath: collects N one-bit
// samples over valid/ready, then presents the registered N*N match matrix
// on a valid/ready output. Defining PAIRMATCH_POPCNT_EN adds match_count,
// the popcount of the registered matrix.
module pairmatch_seq
    import pairmatch_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic                        in_bit,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N*N-1:0]              out_match,
    output logic [7:0]                  frame_cnt
`ifdef PAIRMATCH_POPCNT_EN
    ,
    output logic [$clog2(N*N+1)-1:0]    match_count
`endif
);

    localparam int CW = $clog2(N);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    samples;
    logic [N-1:0]    samples_next;
    logic [N*N-1:0]  matrix_next;
    logic            accept;

    // The block is receptive exactly while collecting, and never during reset.
    assign in_ready = !reset && (state == COLLECT);
    assign accept   = in_valid && in_ready;

    // Sample vector as it will look once the current bit lands in slot cnt.
    always_comb begin
        samples_next      = samples;
        samples_next[cnt] = in_bit;
    end

    pairmatch_matrix #(.N(N)) u_matrix (
        .samples (samples_next),
        .matrix  (matrix_next)
    );

`ifdef PAIRMATCH_POPCNT_EN
    logic [$clog2(N*N+1)-1:0] pop_next;

    // Ones count of the matrix about to be registered, so both update together.
    always_comb begin
        pop_next = '0;
        for (int k = 0; k < N * N; k++) begin
            pop_next = pop_next + ($clog2(N*N+1))'(matrix_next[k]);
        end
    end
`endif

    // Sequencer: reset, then clear, then accept/handoff in descending priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the sample register is only N flops, so it is reset too;
            // a frame after reset therefore never sees stale bits.
            state     <= COLLECT;
            cnt       <= '0;
            samples   <= '0;
            out_valid <= 1'b0;
            out_match <= '0;
            frame_cnt <= '0;
`ifdef PAIRMATCH_POPCNT_EN
            match_count <= '0;
`endif
        end else if (clear) begin
            // Abort: the result register keeps its last value, only validity drops.
            state     <= COLLECT;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        // NOTE: non-blocking assignments keep every register
                        // update based on the pre-edge values.
                        samples <= samples_next;
                        if (cnt == CW'(N - 1)) begin
                            out_match <= matrix_next;
`ifdef PAIRMATCH_POPCNT_EN
                            match_count <= pop_next;
`endif
                            cnt       <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_pairmatch_seq.sv
// Self-checking bench for pairmatch_seq (N=5): a directed table, hand-written
// corner sequences and a randomized run, all against a queue-based model.
module tb_pairmatch_seq;

    localparam int N  = 5;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NN-1:0] out_match;
    logic [7:0]    frame_cnt;
`ifdef PAIRMATCH_POPCNT_EN
    logic [$clog2(NN+1)-1:0] match_count;
`endif

    int checks = 0;
    int errors = 0;

    pairmatch_seq #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_match (out_match),
        .frame_cnt (frame_cnt)
`ifdef PAIRMATCH_POPCNT_EN
        ,
        .match_count (match_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit            mdl_q[$];
    bit            mdl_hold = 1'b0;
    logic [NN-1:0] mdl_match = '0;
    int            mdl_fcnt = 0;

    // Matrix straight from its definition: row i is s[i] compared with every s[j].
    function automatic logic [NN-1:0] ref_matrix(input bit s[$]);
        logic [NN-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[NN-1-(i*N+j)] = (s[i] == s[j]);
        return r;
    endfunction

    // Advance the model by one clock using the inputs presented at the edge.
    task automatic model_step();
        if (reset) begin
            mdl_q.delete();
            mdl_hold  = 1'b0;
            mdl_match = '0;
            mdl_fcnt  = 0;
        end else if (clear) begin
            mdl_q.delete();
            mdl_hold = 1'b0;
        end else if (!mdl_hold) begin
            if (in_valid) begin
                mdl_q.push_back(in_bit);
                if (mdl_q.size() == N) begin
                    mdl_match = ref_matrix(mdl_q);
                    mdl_q.delete();
                    mdl_hold = 1'b1;
                end
            end
        end else if (out_ready) begin
            mdl_hold = 1'b0;
            mdl_fcnt = (mdl_fcnt + 1) % 256;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("mdl_in_ready",  64'(in_ready),  64'(!reset && !mdl_hold));
        check("mdl_out_valid", 64'(out_valid), 64'(mdl_hold));
        check("mdl_out_match", 64'(out_match), 64'(mdl_match));
        check("mdl_frame_cnt", 64'(frame_cnt), 64'(mdl_fcnt));
`ifdef PAIRMATCH_POPCNT_EN
        check("mdl_match_count", 64'(match_count), 64'($countones(mdl_match)));
`endif
    endtask

    // Present inputs, clock once, then compare on the falling edge.
    task automatic drive(input logic r, input logic c, input logic v, input logic b, input logic rdy);
        reset     = r;
        clear     = c;
        in_valid  = v;
        in_bit    = b;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    // bits[0] is sent first.
    task automatic send_frame(input logic [N-1:0] bits, input logic rdy);
        for (int k = 0; k < N; k++) drive(1'b0, 1'b0, 1'b1, bits[k], rdy);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          rst, clr, vld, b, rdy;
        logic          exp_valid;
        logic [NN-1:0] exp_match;
        logic [7:0]    exp_cnt;
    } vec_t;

    localparam logic [NN-1:0] M_10110 = 25'b10110_01001_10110_10110_01001;
    localparam logic [NN-1:0] M_01010 = 25'b10101_01010_10101_01010_10101;
    localparam logic [NN-1:0] M_ONES  = 25'h1FFFFFF;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 0, 0, 0, 0, 0, '0,      8'd0};
        tbl[1] = '{0, 0, 1, 1, 1, 0, '0,      8'd0};
        tbl[2] = '{0, 0, 1, 0, 1, 0, '0,      8'd0};
        tbl[3] = '{0, 0, 1, 1, 1, 0, '0,      8'd0};
        tbl[4] = '{0, 0, 1, 1, 1, 0, '0,      8'd0};
        tbl[5] = '{0, 0, 1, 0, 1, 1, M_10110, 8'd0};
        tbl[6] = '{0, 0, 0, 0, 1, 0, M_10110, 8'd1};
        tbl[7] = '{0, 0, 0, 0, 0, 0, M_10110, 8'd1};

        @(negedge clk);

        // Basic frame 1,0,1,1,0 with out_ready held high.
        for (int t = 0; t < 8; t++) begin
            drive(tbl[t].rst, tbl[t].clr, tbl[t].vld, tbl[t].b, tbl[t].rdy);
            check($sformatf("tbl%0d_valid", t), 64'(out_valid), 64'(tbl[t].exp_valid));
            check($sformatf("tbl%0d_match", t), 64'(out_match), 64'(tbl[t].exp_match));
            check($sformatf("tbl%0d_fcnt", t),  64'(frame_cnt), 64'(tbl[t].exp_cnt));
`ifdef PAIRMATCH_POPCNT_EN
            if (t == 5) check("tbl_popcount", 64'(match_count), 64'd13);
`endif
        end

        // All-zero frame, then backpressure for three cycles with extra bits offered.
        send_frame(5'b00000, 1'b0);
        check("zero_valid", 64'(out_valid), 64'd1);
        check("zero_match", 64'(out_match), 64'(M_ONES));
`ifdef PAIRMATCH_POPCNT_EN
        check("zero_popcount", 64'(match_count), 64'd25);
`endif
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            check("bp_match_stable", 64'(out_match), 64'(M_ONES));
            check("bp_in_ready",     64'(in_ready),  64'd0);
            check("bp_valid",        64'(out_valid), 64'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_handoff_valid", 64'(out_valid), 64'd0);
        check("bp_handoff_fcnt",  64'(frame_cnt), 64'd2);
        check("bp_in_ready_back", 64'(in_ready),  64'd1);
        send_frame(5'b01101, 1'b0);
        check("bp_no_leak_match", 64'(out_match), 64'(M_10110));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Three bits with gaps, clear, then an all-ones frame.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_partial_valid", 64'(out_valid), 64'd0);
        send_frame(5'b11111, 1'b1);
        check("clr_ones_match", 64'(out_match), 64'(M_ONES));
        check("clr_ones_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ones_fcnt", 64'(frame_cnt), 64'd4);

        // Clear while holding a result, with a simultaneous handoff attempt.
        send_frame(5'b10011, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("hold_clr_valid", 64'(out_valid), 64'd0);
        check("hold_clr_fcnt",  64'(frame_cnt), 64'd4);
        send_frame(5'b01010, 1'b0);
        check("hold_clr_new_match", 64'(out_match), 64'(M_01010));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset after two bits, then a clean frame must start from s[0].
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_in_ready", 64'(in_ready),  64'd0);
        check("rst_mid_match",    64'(out_match), 64'd0);
        check("rst_mid_fcnt",     64'(frame_cnt), 64'd0);
        send_frame(5'b01010, 1'b0);
        check("rst_mid_frame", 64'(out_match), 64'(M_01010));

        // Reset while holding.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_hold_valid", 64'(out_valid), 64'd0);
        check("rst_hold_match", 64'(out_match), 64'd0);
        send_frame(5'b01101, 1'b1);
        check("rst_hold_frame", 64'(out_match), 64'(M_10110));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_hold_fcnt", 64'(frame_cnt), 64'd1);

        // frame_cnt wraps after 256 handoffs.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 256; f++) begin
            send_frame(5'($urandom), 1'b1);
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (f == 254) check("wrap_255", 64'(frame_cnt), 64'd255);
        end
        check("wrap_0", 64'(frame_cnt), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
